// File: rtl/position_accumulator_pkg.sv
// Shared constants for the Q32.33 position accumulator: widths, J1 register map
// and FSM state encoding.
package position_accumulator_pkg;

    localparam int unsigned POS_W   = 65;
    localparam int unsigned FRAC_W  = 33;
    localparam int unsigned DELTA_W = POS_W - FRAC_W;

    localparam logic [2:0] ADDR_SNAP_W0 = 3'd0;
    localparam logic [2:0] ADDR_SNAP_W1 = 3'd1;
    localparam logic [2:0] ADDR_SNAP_W2 = 3'd2;
    localparam logic [2:0] ADDR_SNAP_W3 = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_CLEAR   = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_e;

endpackage

// File: rtl/position_int_add.sv
// Combinational integer-part adder with signed-overflow detection.
module position_int_add
    import position_accumulator_pkg::*;
#(
    parameter int unsigned INT_W = DELTA_W
) (
    input  logic [INT_W-1:0] pos,
    input  logic [INT_W-1:0] delta,
    output logic [INT_W-1:0] sum,
    output logic             ovf
);

    always_comb begin
        sum = pos + delta;
        // Overflow only when both operands share a sign the result does not.
        ovf = (pos[INT_W-1] == delta[INT_W-1]) && (sum[INT_W-1] != pos[INT_W-1]);
    end

endmodule

// File: rtl/position_accumulator.sv
// Q32.33 position accumulator: one signed integer delta per two cycles, sticky
// overflow flag, and a J1 peripheral port for snapshot reads and clearing.
module position_accumulator #(
    parameter int unsigned POS_W   = 65,
    parameter int unsigned DELTA_W = 32
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic               delta_valid_i,
    output logic               delta_ready_o,
    input  logic [DELTA_W-1:0] delta_i,
    input  logic               clear_i,
    input  logic               cs_i,
    input  logic               rd_i,
    input  logic               wr_i,
    input  logic [2:0]         addr_i,
    input  logic [15:0]        d_in,
    output logic [15:0]        d_out,
    output logic [POS_W-1:0]   pos_o,
    output logic               ovf_o
);
    import position_accumulator_pkg::*;

    state_e               state_q, state_d;
    logic [DELTA_W-1:0]   hold_q, hold_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 ovf_q, ovf_d;
    logic [POS_W-1:0]     snap_q, snap_d;
    logic [15:0]          dout_q, dout_d;

    logic                 busy;
    logic                 add_en;
    logic                 accept;
    logic                 clr;
    logic                 rd_en;
    logic [DELTA_W-1:0]   add_sum;
    logic                 add_ovf;
    logic                 write_data_unused;

    // Write data carries no meaning: only the clear address acts on writes, and
    // snapshot bits [15:0] are always returned fresh by the address-0 read.
    assign write_data_unused = ^{d_in, snap_q[15:0]};

    assign clr    = clear_i | (cs_i & wr_i & (addr_i == ADDR_CLEAR));
    assign rd_en  = cs_i & rd_i;
    assign accept = delta_valid_i & delta_ready_o;

    position_int_add #(
        .INT_W(DELTA_W)
    ) u_int_add (
        .pos   (pos_q[POS_W-1:FRAC_W]),
        .delta (hold_q),
        .sum   (add_sum),
        .ovf   (add_ovf)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = ST_ADD;
                ST_ADD:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        delta_ready_o = (state_q == ST_IDLE);
        busy          = (state_q == ST_ADD);
        add_en        = (state_q == ST_ADD);
    end

    always_comb begin
        hold_d = hold_q;
        pos_d  = pos_q;
        ovf_d  = ovf_q;
        if (clr) begin
            hold_d = '0;
            pos_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (accept) hold_d = delta_i;
            if (add_en) begin
                pos_d = {add_sum, pos_q[FRAC_W-1:0]};
                ovf_d = ovf_q | add_ovf;
            end
        end
    end

    // Reads use pre-edge pos/state/flag, so a snapshot never sees a same-edge ADD.
    always_comb begin
        snap_d = snap_q;
        dout_d = dout_q;
        if (rd_en) begin
            case (addr_i)
                ADDR_SNAP_W0: begin
                    snap_d = pos_q;
                    dout_d = pos_q[15:0];
                end
                ADDR_SNAP_W1: dout_d = snap_q[31:16];
                ADDR_SNAP_W2: dout_d = snap_q[47:32];
                ADDR_SNAP_W3: dout_d = snap_q[63:48];
                ADDR_STATUS:  dout_d = {13'b0, busy, ovf_q, snap_q[POS_W-1]};
                default:      dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            hold_q <= '0;
            pos_q  <= '0;
            ovf_q  <= 1'b0;
            snap_q <= '0;
            dout_q <= '0;
        end else begin
            hold_q <= hold_d;
            pos_q  <= pos_d;
            ovf_q  <= ovf_d;
            snap_q <= snap_d;
            dout_q <= dout_d;
        end
    end

    assign pos_o = pos_q;
    assign ovf_o = ovf_q;
    assign d_out = dout_q;

endmodule

// File: tb/tb_position_accumulator.sv
// Bench for position_accumulator: directed scenarios plus randomized traffic
// against an arithmetic model of position, overflow, snapshot and J1 reads.
module tb_position_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, clear, cs, rd, wr, ovf;
    logic [31:0] delta;
    logic [2:0]  addr;
    logic [15:0] d_in, d_out;
    logic [64:0] pos;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    position_accumulator #(
        .POS_W   (65),
        .DELTA_W (32)
    ) dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst_n),
        .delta_valid_i (valid),
        .delta_ready_o (ready),
        .delta_i       (delta),
        .clear_i       (clear),
        .cs_i          (cs),
        .rd_i          (rd),
        .wr_i          (wr),
        .addr_i        (addr),
        .d_in          (d_in),
        .d_out         (d_out),
        .pos_o         (pos),
        .ovf_o         (ovf)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: integer position as a signed int, fraction always zero; a pending
    // delta waits one edge before being added.
    int          m_int;
    bit          m_ovf;
    int          m_pend[$];
    logic [64:0] m_snap;
    logic [15:0] m_dout;
    bit          check_en = 0;

    logic [64:0] pre_pos;
    bit          pre_busy, pre_ovf, m_clr;
    longint      s;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_int = 0; m_ovf = 0; m_pend.delete(); m_snap = '0; m_dout = '0;
        end else begin
            pre_pos  = {m_int[31:0], 33'b0};
            pre_busy = (m_pend.size() != 0);
            pre_ovf  = m_ovf;
            m_clr    = clear || (cs && wr && addr == 3'd7);
            if (cs && rd) begin
                case (addr)
                    3'd0: begin m_snap = pre_pos; m_dout = pre_pos[15:0]; end
                    3'd1: m_dout = m_snap[31:16];
                    3'd2: m_dout = m_snap[47:32];
                    3'd3: m_dout = m_snap[63:48];
                    3'd4: m_dout = {13'b0, pre_busy, pre_ovf, m_snap[64]};
                    default: m_dout = 16'h0;
                endcase
            end
            if (m_clr) begin
                m_int = 0; m_ovf = 0; m_pend.delete();
            end else if (pre_busy) begin
                s = longint'(m_int) + longint'(m_pend.pop_front());
                if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
                m_int = int'(s[31:0]);
            end else if (valid) begin
                m_pend.push_back(int'(delta));
            end
        end
        #2;
        if (rst_n && check_en) begin
            check("pos_o", pos, {m_int[31:0], 33'b0});
            check("ovf_o", {64'b0, ovf}, {64'b0, m_ovf});
            check("delta_ready_o", {64'b0, ready}, {64'b0, (m_pend.size() == 0)});
            check("d_out", {49'b0, d_out}, {49'b0, m_dout});
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin @(negedge clk); n++; end
        if (!ready) check("ready_timeout", {64'b0, ready}, 65'd1);
        valid = 1'b1; delta = d;
        @(negedge clk); valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic j1_read(input logic [2:0] a, output logic [15:0] data);
        @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        data = d_out;
    endtask

    task automatic j1_write(input logic [2:0] a);
        @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; d_in = 16'hBEEF;
        @(negedge clk); cs = 1'b0; wr = 1'b0;
    endtask

    logic [15:0] rdata;
    logic [5:0]  rpat;
    int          accepts;

    initial begin
        rst_n = 1'b0; valid = 0; delta = '0; clear = 0; cs = 0; rd = 0; wr = 0;
        addr = '0; d_in = '0;
        repeat (2) @(negedge clk);
        check("reset_pos", pos, 65'd0);
        check("reset_ovf", {64'b0, ovf}, 65'd0);
        check("reset_ready", {64'b0, ready}, 65'd1);
        check("reset_dout", {49'b0, d_out}, 65'd0);
        rst_n = 1'b1; check_en = 1;

        // +5 accepted on the first edge after release, then -3
        valid = 1'b1; delta = 32'd5;
        @(posedge clk); #2;
        check("add5_not_yet", {33'b0, pos[64:33]}, 65'd0);
        @(negedge clk); valid = 1'b0;
        @(posedge clk); #2;
        check("add5_int", {33'b0, pos[64:33]}, 65'd5);
        @(negedge clk); valid = 1'b1; delta = -32'sd3;
        @(posedge clk); #2;
        check("sub3_not_yet", {33'b0, pos[64:33]}, 65'd5);
        @(negedge clk); valid = 1'b0;
        @(posedge clk); #2;
        check("sub3_int", {33'b0, pos[64:33]}, 65'd2);
        check("sub3_frac", {32'b0, pos[32:0]}, 65'd0);
        check("sub3_ovf", {64'b0, ovf}, 65'd0);
        check("model_pin_2", 65'(m_int), 65'd2);

        // signed overflow of the integer part, sticky afterwards
        send(32'h7FFF_FFFD);
        check("max_int", {33'b0, pos[64:33]}, 65'h7FFF_FFFF);
        check("max_ovf", {64'b0, ovf}, 65'd0);
        send(32'd1);
        check("wrap_int", {33'b0, pos[64:33]}, 65'h8000_0000);
        check("wrap_ovf", {64'b0, ovf}, 65'd1);
        send(32'hFFFF_FFFF);
        check("sticky_ovf", {64'b0, ovf}, 65'd1);
        check("model_pin_ovf", {64'b0, m_ovf}, 65'd1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_pos", pos, 65'd0);
        check("clear_ovf", {64'b0, ovf}, 65'd0);

        // valid held for six cycles
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rpat[5-i] = ready;
            if (ready) accepts++;
            valid = 1'b1; delta = 32'(i + 1);
        end
        @(negedge clk); valid = 1'b0;
        check("ready_pattern", {59'b0, rpat}, 65'b101010);
        check("accept_count", 65'(accepts), 65'd3);
        check("six_cycle_int", {33'b0, pos[64:33]}, 65'd9);

        // clear beats a same-edge accept of +9
        @(negedge clk); valid = 1'b1; delta = 32'd9; clear = 1'b1;
        @(negedge clk); valid = 1'b0; clear = 1'b0;
        check("clr_acc_pos", pos, 65'd0);
        check("clr_acc_idle", {64'b0, ready}, 65'd1);
        @(negedge clk); @(negedge clk);
        check("clr_acc_dropped", pos, 65'd0);

        // snapshot reads; fraction is never reachable, so use int 0x91A2B3C4
        send(32'h91A2_B3C4);
        check("snap_src", pos, {32'h91A2_B3C4, 33'b0});
        j1_read(3'd0, rdata); check("rd0", {49'b0, rdata}, 65'h0000);
        @(negedge clk);       check("rd0_hold", {49'b0, d_out}, 65'h0000);
        j1_read(3'd1, rdata); check("rd1", {49'b0, rdata}, 65'h0000);
        send(32'd7);
        j1_read(3'd2, rdata); check("rd2", {49'b0, rdata}, 65'h6788);
        @(negedge clk);       check("rd2_hold", {49'b0, d_out}, 65'h6788);
        j1_read(3'd3, rdata); check("rd3", {49'b0, rdata}, 65'h2345);
        j1_read(3'd4, rdata); check("rd4", {49'b0, rdata}, 65'h0001);
        j1_read(3'd5, rdata); check("rd5", {49'b0, rdata}, 65'h0000);

        // force ovf, then async reset mid-ADD of delta 100
        send(32'h8000_0000);
        check("neg_ovf", {64'b0, ovf}, 65'd1);
        @(negedge clk); valid = 1'b1; delta = 32'd100;
        @(negedge clk); valid = 1'b0;
        check("mid_add_busy", {64'b0, ready}, 65'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_pos", pos, 65'd0);
        check("async_ovf", {64'b0, ovf}, 65'd0);
        check("async_ready", {64'b0, ready}, 65'd1);
        check("async_dout", {49'b0, d_out}, 65'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_pos", pos, 65'd0);

        // J1 writes: only address 7 clears
        send(32'd12);
        j1_write(3'd3);
        check("wr3_ignored", {33'b0, pos[64:33]}, 65'd12);
        j1_write(3'd7);
        check("wr7_clear", pos, 65'd0);

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       delta = 32'($urandom_range(0, 15));
                1:       delta = -32'($urandom_range(0, 15));
                default: delta = $urandom;
            endcase
            clear = ($urandom_range(0, 31) == 0);
            cs    = 1'($urandom_range(0, 1));
            rd    = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            d_in  = 16'($urandom);
        end
        @(negedge clk);
        valid = 0; clear = 0; cs = 0; rd = 0; wr = 0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
